// File: rtl/traffic_phase_ctrl.sv
// Two-road intersection phase sequencer: green/yellow/all-red per road,
// pedestrian walk via extended all-red, and flashing-yellow night mode.
module traffic_phase_ctrl #(
  parameter int unsigned GREEN_SEC  = 25,
  parameter int unsigned YELLOW_SEC = 3,
  parameter int unsigned ALLRED_SEC = 2,
  parameter int unsigned WALK_SEC   = 10,
  parameter int unsigned CW         = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sec,
  input  logic          ped_req,
  input  logic          night,
  output logic [2:0]    ns_light,
  output logic [2:0]    ew_light,
  output logic          ped_walk,
  output logic [CW-1:0] remain
);

  typedef enum logic [2:0] {AR1, NSG, NSY, AR2, EWG, EWY, FLASH} state_t;

  localparam logic [2:0] LR   = 3'b100;
  localparam logic [2:0] LY   = 3'b010;
  localparam logic [2:0] LG   = 3'b001;
  localparam logic [2:0] LOFF = 3'b000;

  localparam logic [CW-1:0] D_GREEN  = CW'(GREEN_SEC);
  localparam logic [CW-1:0] D_YELLOW = CW'(YELLOW_SEC);
  localparam logic [CW-1:0] D_ALLRED = CW'(ALLRED_SEC);
  localparam logic [CW-1:0] D_WALK   = CW'(WALK_SEC);
  localparam logic [CW-1:0] ONE      = CW'(1);

  state_t        state, state_n, succ;
  logic [CW-1:0] remain_n;
  logic          ped_pend, pend_n;
  logic          flash_ph, flash_n;
  logic          walk, walk_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= AR1;
      remain   <= D_ALLRED;
      ped_pend <= 1'b0;
      flash_ph <= 1'b0;
      walk     <= 1'b0;
    end else begin
      state    <= state_n;
      remain   <= remain_n;
      ped_pend <= pend_n;
      flash_ph <= flash_n;
      walk     <= walk_n;
    end
  end

  always_comb begin
    succ = AR1;
    unique case (state)
      AR1:     succ = NSG;
      NSG:     succ = NSY;
      NSY:     succ = AR2;
      AR2:     succ = EWG;
      EWG:     succ = EWY;
      EWY:     succ = AR1;
      default: succ = AR1;
    endcase
  end

  always_comb begin
    state_n  = state;
    remain_n = remain;
    pend_n   = ped_pend;
    flash_n  = flash_ph;
    walk_n   = walk;
    if (state == FLASH) begin
      // ped_req is ignored here; only an already-latched request is served on exit
      if (sec) begin
        flash_n = ~flash_ph;
        if (!night) begin
          state_n = AR1;
          flash_n = 1'b0;
          if (ped_pend) begin
            remain_n = D_WALK;
            walk_n   = 1'b1;
            pend_n   = 1'b0;
          end else begin
            remain_n = D_ALLRED;
            walk_n   = 1'b0;
          end
        end
      end
    end else begin
      pend_n = ped_pend | ped_req;
      if (sec) begin
        if (remain > ONE) begin
          remain_n = remain - ONE;
        end else if ((state == AR1 || state == AR2) && night) begin
          // pending pedestrian is kept across the night period
          state_n  = FLASH;
          flash_n  = 1'b1;
          remain_n = '0;
          walk_n   = 1'b0;
        end else begin
          state_n = succ;
          if (succ == AR1 || succ == AR2) begin
            if (ped_pend | ped_req) begin
              remain_n = D_WALK;
              walk_n   = 1'b1;
              pend_n   = 1'b0;
            end else begin
              remain_n = D_ALLRED;
              walk_n   = 1'b0;
            end
          end else begin
            remain_n = (succ == NSG || succ == EWG) ? D_GREEN : D_YELLOW;
            walk_n   = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    ns_light = LR;
    ew_light = LR;
    ped_walk = 1'b0;
    unique case (state)
      NSG:   ns_light = LG;
      NSY:   ns_light = LY;
      EWG:   ew_light = LG;
      EWY:   ew_light = LY;
      AR1, AR2: ped_walk = walk;
      FLASH: begin
        ns_light = flash_ph ? LY : LOFF;
        ew_light = flash_ph ? LY : LOFF;
      end
      default: begin
        ns_light = LR;
        ew_light = LR;
      end
    endcase
  end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Scoreboard bench for traffic_phase_ctrl: a phase-schedule reference model
// predicts every cycle's outputs; a monitor compares them against the DUT.
module tb_traffic_phase_ctrl;

  localparam int GREEN  = 25;
  localparam int YELLOW = 3;
  localparam int ALLRED = 2;
  localparam int WALK   = 10;
  localparam int CW     = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          sec = 1'b0;
  logic          ped_req = 1'b0;
  logic          night = 1'b0;
  logic [2:0]    ns_light, ew_light;
  logic          ped_walk;
  logic [CW-1:0] remain;

  traffic_phase_ctrl #(
    .GREEN_SEC(GREEN), .YELLOW_SEC(YELLOW), .ALLRED_SEC(ALLRED),
    .WALK_SEC(WALK), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst), .sec(sec), .ped_req(ped_req), .night(night),
    .ns_light(ns_light), .ew_light(ew_light), .ped_walk(ped_walk), .remain(remain)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]    ns;
    logic [2:0]    ew;
    logic          w;
    logic [CW-1:0] rem;
  } exp_t;

  exp_t q[$];
  int n_pass = 0;
  int n_total = 0;

  // Reference model: phase index into the fixed cycle (0..5), 6 = flashing.
  // Time is tracked as elapsed seconds against the phase's duration.
  int ph, elapsed, dur;
  bit mwalk, pend, fl;
  logic [2:0] ns_tab [6] = '{3'b100, 3'b001, 3'b010, 3'b100, 3'b100, 3'b100};
  logic [2:0] ew_tab [6] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b010};

  function automatic bit is_allred(int p);
    return p == 0 || p == 3;
  endfunction

  task automatic model_reset();
    ph = 0; elapsed = 0; dur = ALLRED; mwalk = 0; pend = 0; fl = 0;
  endtask

  task automatic enter(int p, bit served);
    ph = p;
    elapsed = 0;
    if (is_allred(p)) begin
      mwalk = served;
      dur = served ? WALK : ALLRED;
      if (served) pend = 0;
    end else begin
      mwalk = 0;
      dur = (p == 1 || p == 4) ? GREEN : YELLOW;
    end
  endtask

  task automatic model_step(bit s, bit p, bit n);
    bit pl;
    if (ph == 6) begin
      if (s) begin
        fl = !fl;
        if (!n) begin
          fl = 0;
          enter(0, pend);
        end
      end
    end else begin
      pl = pend | p;
      pend = pl;
      if (s) begin
        elapsed++;
        if (elapsed == dur) begin
          if (is_allred(ph) && n) begin
            ph = 6; fl = 1; mwalk = 0; elapsed = 0;
          end else begin
            enter((ph + 1) % 6, pl);
          end
        end
      end
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    if (ph == 6) begin
      e.ns = fl ? 3'b010 : 3'b000;
      e.ew = e.ns;
      e.w = 1'b0;
      e.rem = '0;
    end else begin
      e.ns = ns_tab[ph];
      e.ew = ew_tab[ph];
      e.w = mwalk;
      e.rem = CW'(dur - elapsed);
    end
    return e;
  endfunction

  // Drive one clock cycle of inputs and queue the outputs expected after its edge.
  task automatic cyc(bit r, bit s, bit p, bit n);
    @(negedge clk);
    rst = r; sec = s; ped_req = p; night = n;
    if (!r) model_reset();
    else model_step(s, p, n);
    q.push_back(model_out());
  endtask

  task automatic sec_tick(bit p, bit n);
    cyc(1, 0, 0, n);
    cyc(1, 0, 0, n);
    cyc(1, 0, 0, n);
    cyc(1, 1, p, n);
  endtask

  task automatic timeout(string name);
    n_total++;
    $display("FAIL %s: wait bound expired (actual phase %0d, required target)", name, ph);
  endtask

  // Advance one tick at a time until the model reaches phase p with the given elapsed count.
  task automatic run_to(int p, int el, bit n, string name);
    int k = 0;
    while (!(ph == p && elapsed == el) && k < 200) begin
      sec_tick(0, n);
      k++;
    end
    if (k >= 200) timeout(name);
  endtask

  task automatic async_reset();
    @(negedge clk);
    sec = 0; ped_req = 0; night = 0;
    model_reset();
    q.push_back(model_out());
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin : monitor
    exp_t e, a;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        a = '{ns: ns_light, ew: ew_light, w: ped_walk, rem: remain};
        n_total++;
        if (a === e) n_pass++;
        else $display("FAIL out @%0t: actual ns=%b ew=%b walk=%b remain=%0d, required ns=%b ew=%b walk=%b remain=%0d",
                      $time, a.ns, a.ew, a.w, a.rem, e.ns, e.ew, e.w, e.rem);
      end
    end
  end

  initial begin : driver
    bit nv;
    model_reset();
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    // normal cycle from reset release
    run_to(0, 0, 0, "cycle1");
    repeat (2 * 60) sec_tick(0, 0);
    // pedestrian request during NSG tick 5
    run_to(1, 4, 0, "ped_nsg");
    sec_tick(1, 0);
    run_to(0, 1, 0, "ped_ar1");
    // night raised mid-EWG, flashing, then drop
    run_to(4, 10, 0, "night_ewg");
    repeat (40) sec_tick(0, 1);
    run_to(6, 0, 1, "flash_in");
    repeat (5) sec_tick(0, 1);
    repeat (8) sec_tick(0, 0);
    // request on the exact cycle AR2 is entered
    run_to(2, YELLOW - 1, 0, "ar2_edge");
    sec_tick(1, 0);
    repeat (14) sec_tick(0, 0);
    // pedestrian pending at AR2 expiry with night up
    run_to(3, 0, 0, "ar2_pend");
    sec_tick(1, 1);
    run_to(6, 0, 1, "flash_pend");
    repeat (3) sec_tick(0, 1);
    repeat (15) sec_tick(0, 0);
    // asynchronous reset mid-NSG
    run_to(1, 5, 0, "nsg_rst");
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    async_reset();
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    repeat (70) sec_tick(0, 0);
    // randomized traffic
    nv = 0;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 299) == 0) nv = !nv;
      if ($urandom_range(0, 2999) == 0) begin
        async_reset();
        cyc(0, 0, 0, nv);
      end else begin
        cyc(1, $urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0, nv);
      end
    end
    repeat (3) @(posedge clk);
    #3;
    if (q.size() != 0) begin
      n_total++;
      $display("FAIL drain: actual %0d pending, required 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
